// File: rtl/ds_pkg.sv
// -----------------------------------------------------------------------------
// ds_pkg
// Shared definitions for the delta-sigma loop stages: datapath width,
// saturation limits, default feedback level, overload defaults, the
// integrator state enum and small arithmetic helpers.
// -----------------------------------------------------------------------------
package ds_pkg;

    // Datapath width (two's complement), fixed across all coefficient stages.
    localparam int W  = 41;
    // Extended width used for one integration step: two guard bits are enough
    // for the sum of three W-bit operands.
    localparam int WX = W + 2;

    localparam logic signed [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};  //  2^40 - 1
    localparam logic signed [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};  // -2^40

    // Quantizer feedback magnitude, 2^36.
    localparam logic signed [W-1:0] FB_LEVEL_DEFAULT = W'(64'sd68719476736);

    localparam int OVL_N_DEFAULT    = 4;
    localparam int OVL_HOLD_DEFAULT = 16;

    // Overload event counter width and its ceiling.
    localparam int               CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } integ_state_e;

    // Sign-extend a datapath word to the step width.
    function automatic logic signed [WX-1:0] sext_wx(input logic signed [W-1:0] v);
        return {{(WX-W){v[W-1]}}, v};
    endfunction

    // Increment that sticks at the counter ceiling.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/ds_integ_stage_if.sv
// -----------------------------------------------------------------------------
// ds_integ_stage_if
// Bundle of the integrator stage control/data signals.
//   master : drives ce, clr, in, fb; observes the stage outputs.
//   slave  : the integrator itself; consumes ce/clr/in/fb and drives
//            out, out_valid, sat, recovering, ovf, ovf_cnt.
// -----------------------------------------------------------------------------
interface ds_integ_stage_if;
    import ds_pkg::*;

    logic                 ce;          // sample strobe
    logic                 clr;         // synchronous clear of all state
    logic signed [W-1:0]  in;          // scaled sample from coefficient stage
    logic                 fb;          // quantizer output (1 -> subtract level)

    logic signed [W-1:0]  out;         // integrator state
    logic                 out_valid;   // pulse, cycle after each accepted ce
    logic                 sat;         // last step clamped
    logic                 recovering;  // in the recovery window
    logic                 ovf;         // sticky overload flag
    logic [CNT_W-1:0]     ovf_cnt;     // overload event count, saturating

    modport master (
        output ce, clr, in, fb,
        input  out, out_valid, sat, recovering, ovf, ovf_cnt
    );

    modport slave (
        input  ce, clr, in, fb,
        output out, out_valid, sat, recovering, ovf, ovf_cnt
    );

endinterface

// File: rtl/ds_sat_add.sv
// -----------------------------------------------------------------------------
// ds_sat_add
// Combinational integration step: acc + in -/+ LEVEL evaluated in W+2 bits,
// then clamped to the W-bit signed range.
//   acc_i : current integrator state
//   in_i  : scaled input sample
//   sub_i : 1 -> subtract LEVEL, 0 -> add LEVEL
//   sum_o : clamped result
//   sat_o : 1 when the result was clamped
// -----------------------------------------------------------------------------
module ds_sat_add
    import ds_pkg::*;
#(
    parameter logic signed [W-1:0] LEVEL = FB_LEVEL_DEFAULT
) (
    input  logic signed [W-1:0] acc_i,
    input  logic signed [W-1:0] in_i,
    input  logic                sub_i,
    output logic signed [W-1:0] sum_o,
    output logic                sat_o
);

    logic signed [WX-1:0] acc_x;
    logic signed [WX-1:0] in_x;
    logic signed [WX-1:0] lvl_x;
    logic signed [WX-1:0] sum_x;
    // Sign bit plus the two guard bits; the value fits in W bits only when
    // all of these agree.
    logic [WX-W:0]        top_bits;

    always_comb begin
        acc_x    = sext_wx(acc_i);
        in_x     = sext_wx(in_i);
        lvl_x    = sext_wx(LEVEL);
        sum_x    = sub_i ? (acc_x + in_x - lvl_x) : (acc_x + in_x + lvl_x);
        top_bits = sum_x[WX-1:W-1];

        sum_o = sum_x[W-1:0];
        sat_o = 1'b0;
        if ((top_bits != '0) && (top_bits != '1)) begin
            sat_o = 1'b1;
            sum_o = sum_x[WX-1] ? SAT_MIN : SAT_MAX;
        end
    end

endmodule

// File: rtl/ds_integ_stage.sv
// -----------------------------------------------------------------------------
// ds_integ_stage
// Saturating integrator of the delta-sigma loop with overload recovery.
// Each ce adds the scaled sample and the -/+FB_LEVEL feedback to the state.
// OVL_N consecutive clamped steps declare overload: the state is zeroed and
// held there for OVL_HOLD strobes before integration resumes.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of ds_integ_stage_if (ce, clr, in, fb in;
//                out, out_valid, sat, recovering, ovf, ovf_cnt out)
// -----------------------------------------------------------------------------
module ds_integ_stage
    import ds_pkg::*;
#(
    parameter logic signed [W-1:0] FB_LEVEL = FB_LEVEL_DEFAULT,
    parameter int                  OVL_N    = OVL_N_DEFAULT,
    parameter int                  OVL_HOLD = OVL_HOLD_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    ds_integ_stage_if.slave     bus
);

    localparam int RUN_W  = (OVL_N    > 1) ? $clog2(OVL_N)    : 1;
    localparam int HOLD_W = (OVL_HOLD > 1) ? $clog2(OVL_HOLD) : 1;
    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(OVL_N - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(OVL_HOLD - 1);

    integ_state_e         state_q,     state_d;
    logic signed [W-1:0]  out_q,       out_d;
    logic                 out_valid_q, out_valid_d;
    logic                 sat_q,       sat_d;
    logic                 ovf_q,       ovf_d;
    logic [CNT_W-1:0]     ovf_cnt_q,   ovf_cnt_d;
    logic [RUN_W-1:0]     sat_run_q,   sat_run_d;
    logic [HOLD_W-1:0]    hold_cnt_q,  hold_cnt_d;

    logic signed [W-1:0]  step_sum;
    logic                 step_sat;

    ds_sat_add #(
        .LEVEL (FB_LEVEL)
    ) u_sat_add (
        .acc_i (out_q),
        .in_i  (bus.in),
        .sub_i (bus.fb),
        .sum_o (step_sum),
        .sat_o (step_sat)
    );

    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        sat_d       = sat_q;
        ovf_d       = ovf_q;
        ovf_cnt_d   = ovf_cnt_q;
        sat_run_d   = sat_run_q;
        hold_cnt_d  = hold_cnt_q;

        if (bus.clr) begin
            // Clear wins over a simultaneous ce: no step, no valid pulse.
            state_d    = RUN;
            out_d      = '0;
            sat_d      = 1'b0;
            ovf_d      = 1'b0;
            ovf_cnt_d  = '0;
            sat_run_d  = '0;
            hold_cnt_d = '0;
        end else if (bus.ce) begin
            out_valid_d = 1'b1;
            case (state_q)
                RUN: begin
                    out_d = step_sum;
                    sat_d = step_sat;
                    if (!step_sat) begin
                        sat_run_d = '0;
                    end else if (sat_run_q == RUN_LAST) begin
                        // This clamped step completes the overload run: drop
                        // the state to zero in the same cycle as the switch.
                        out_d      = '0;
                        sat_run_d  = '0;
                        hold_cnt_d = '0;
                        state_d    = RECOVER;
                        ovf_d      = 1'b1;
                        ovf_cnt_d  = sat_inc(ovf_cnt_q);
                    end else begin
                        sat_run_d = sat_run_q + 1'b1;
                    end
                end
                RECOVER: begin
                    // Input and feedback are ignored while the loop settles.
                    out_d = '0;
                    sat_d = 1'b0;
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d    = RUN;
                        hold_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
            ovf_q       <= 1'b0;
            ovf_cnt_q   <= '0;
            sat_run_q   <= '0;
            hold_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            sat_q       <= sat_d;
            ovf_q       <= ovf_d;
            ovf_cnt_q   <= ovf_cnt_d;
            sat_run_q   <= sat_run_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    assign bus.out        = out_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.sat        = sat_q;
    assign bus.recovering = (state_q == RECOVER);
    assign bus.ovf        = ovf_q;
    assign bus.ovf_cnt    = ovf_cnt_q;

endmodule

// File: tb/tb_ds_integ_stage.sv
// -----------------------------------------------------------------------------
// tb_ds_integ_stage
// Directed bench for ds_integ_stage. Stimulus pushes the hand-computed
// response of every ce into a queue; a monitor pops and compares on each
// out_valid. Reset, clear and asynchronous reset are checked directly.
// -----------------------------------------------------------------------------
module tb_ds_integ_stage;
    import ds_pkg::*;

    localparam logic signed [W-1:0] P36  = W'(64'sd68719476736);     //  2^36
    localparam logic signed [W-1:0] P39  = W'(64'sd549755813888);    //  2^39
    localparam logic signed [W-1:0] MAXV = W'(64'sd1099511627775);   //  2^40-1
    localparam logic signed [W-1:0] MINV = W'(-64'sd1099511627776);  // -2^40

    typedef struct packed {
        logic signed [W-1:0] out;
        logic                sat;
        logic                rec;
        logic                ovf;
        logic [CNT_W-1:0]    cnt;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    exp_t  exp_q[$];
    string name_q[$];

    always #5 clk = ~clk;

    ds_integ_stage_if bus ();

    ds_integ_stage #(
        .FB_LEVEL (FB_LEVEL_DEFAULT),
        .OVL_N    (4),
        .OVL_HOLD (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string nm, input logic signed [63:0] act,
                       input logic signed [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    function automatic logic [CNT_W-1:0] cap(input int v);
        return (v > 255) ? 8'd255 : 8'(v);
    endfunction

    // One ce with its expected response queued for the monitor.
    task automatic step(input logic signed [W-1:0] din, input logic dfb,
                        input logic signed [W-1:0] eo, input logic es,
                        input logic er, input logic eov,
                        input logic [CNT_W-1:0] ec, input string nm);
        exp_t e;
        e.out = eo;
        e.sat = es;
        e.rec = er;
        e.ovf = eov;
        e.cnt = ec;
        exp_q.push_back(e);
        name_q.push_back(nm);
        bus.ce = 1'b1;
        bus.in = din;
        bus.fb = dfb;
        @(posedge clk);
        #1;
        bus.ce = 1'b0;
    endtask

    // OVL_HOLD strobes in RECOVER: out stays 0, recovering drops on the last.
    task automatic recover_window(input logic [CNT_W-1:0] cnt,
                                  input logic signed [W-1:0] din, input logic dfb);
        for (int i = 0; i < 16; i++)
            step(din, dfb, '0, 1'b0, (i != 15), 1'b1, cnt, $sformatf("recover_%0d", i));
    endtask

    // Four clamped steps from a state above -2^36: the fourth declares overload.
    task automatic overload_event(input logic ovf_before, input logic [CNT_W-1:0] cnt_before,
                                  input logic [CNT_W-1:0] cnt_after);
        for (int i = 0; i < 3; i++)
            step(MAXV, 1'b0, MAXV, 1'b1, 1'b0, ovf_before, cnt_before, $sformatf("sat_step_%0d", i));
        step(MAXV, 1'b0, '0, 1'b1, 1'b1, 1'b1, cnt_after, "overload_step");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin : monitor
        exp_t  e;
        string nm;
        forever begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_valid: got out_valid=1 out=%0d, required no output", bus.out);
                end else begin
                    e  = exp_q.pop_front();
                    nm = name_q.pop_front();
                    n_vec++;
                    if ({bus.out, bus.sat, bus.recovering, bus.ovf, bus.ovf_cnt} !== e) begin
                        n_err++;
                        $display("FAIL %s: got out=%0d sat=%0b rec=%0b ovf=%0b cnt=%0d, required out=%0d sat=%0b rec=%0b ovf=%0b cnt=%0d",
                                 nm, bus.out, bus.sat, bus.recovering, bus.ovf, bus.ovf_cnt,
                                 e.out, e.sat, e.rec, e.ovf, e.cnt);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        bus.ce  = 1'b0;
        bus.clr = 1'b0;
        bus.in  = '0;
        bus.fb  = 1'b0;
        #1 rst_n = 1'b0;
        idle(2);
        chk("reset_out",       bus.out,        0);
        chk("reset_out_valid", bus.out_valid,  0);
        chk("reset_sat",       bus.sat,        0);
        chk("reset_recovering", bus.recovering, 0);
        chk("reset_ovf",       bus.ovf,        0);
        chk("reset_ovf_cnt",   bus.ovf_cnt,    0);
        rst_n = 1'b1;
        idle(1);

        // Feedback alone: +2^36 then back to 0.
        step('0, 1'b0, P36, 1'b0, 1'b0, 1'b0, 8'd0, "fb0_add_level");
        idle(1);
        chk("valid_single_pulse", bus.out_valid, 0);
        chk("hold_without_ce",    bus.out,       P36);
        step('0, 1'b1, '0, 1'b0, 1'b0, 1'b0, 8'd0, "fb1_sub_level");

        // Positive overload from zero, back to back.
        step(P39, 1'b0, W'(64'sd618475290624), 1'b0, 1'b0, 1'b0, 8'd0, "pos_step1");
        step(P39, 1'b0, MAXV, 1'b1, 1'b0, 1'b0, 8'd0, "pos_step2");
        step(P39, 1'b0, MAXV, 1'b1, 1'b0, 1'b0, 8'd0, "pos_step3");
        step(P39, 1'b0, MAXV, 1'b1, 1'b0, 1'b0, 8'd0, "pos_step4");
        step(P39, 1'b0, '0,   1'b1, 1'b1, 1'b1, 8'd1, "pos_step5_overload");

        // Recovery ignores a full-scale negative input.
        recover_window(8'd1, MINV, 1'b1);
        step(W'(64'sd5), 1'b0, W'(64'sd68719476741), 1'b0, 1'b0, 1'b1, 8'd1, "first_after_recover");

        // Negative clamp, then a clean step that must reset the saturation run.
        step(W'(-64'sd1099511627771), 1'b1, W'(-64'sd1099511627766), 1'b0, 1'b0, 1'b1, 8'd1, "near_neg_limit");
        step(W'(-64'sd100), 1'b1, MINV, 1'b1, 1'b0, 1'b1, 8'd1, "neg_clamp");
        step(MAXV, 1'b0, W'(64'sd68719476735), 1'b0, 1'b0, 1'b1, 8'd1, "unsat_after_clamp");
        overload_event(1'b1, 8'd1, 8'd2);

        recover_window(8'd2, '0, 1'b0);
        overload_event(1'b1, 8'd2, 8'd3);
        step('0, 1'b0, '0, 1'b0, 1'b1, 1'b1, 8'd3, "recover_before_clr");

        // Clear together with ce while recovering.
        bus.clr = 1'b1;
        bus.ce  = 1'b1;
        bus.in  = P39;
        @(posedge clk);
        #1;
        bus.clr = 1'b0;
        bus.ce  = 1'b0;
        chk("clr_out",        bus.out,        0);
        chk("clr_out_valid",  bus.out_valid,  0);
        chk("clr_sat",        bus.sat,        0);
        chk("clr_recovering", bus.recovering, 0);
        chk("clr_ovf",        bus.ovf,        0);
        chk("clr_ovf_cnt",    bus.ovf_cnt,    0);

        // 260 overload events: counter sticks at 255.
        for (int i = 1; i <= 260; i++) begin
            overload_event(i > 1, cap(i - 1), cap(i));
            if (i < 260) recover_window(cap(i), '0, 1'b0);
        end
        for (int i = 0; i < 3; i++)
            step('0, 1'b0, '0, 1'b0, 1'b1, 1'b1, 8'd255, "recover_before_rst");

        // Asynchronous reset in the middle of recovery.
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_out",        bus.out,        0);
        chk("async_rst_out_valid",  bus.out_valid,  0);
        chk("async_rst_sat",        bus.sat,        0);
        chk("async_rst_recovering", bus.recovering, 0);
        chk("async_rst_ovf",        bus.ovf,        0);
        chk("async_rst_ovf_cnt",    bus.ovf_cnt,    0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);
        step('0, 1'b0, P36, 1'b0, 1'b0, 1'b0, 8'd0, "run_after_async_rst");

        idle(3);
        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ds_integ_stage.md
# ds_integ_stage

Clocked integrator stage of the delta-sigma modulator loop. It consumes the signed 41-bit coefficient-scaled sample produced by the constant-multiplier stage (for example the ×0.18603515625 stage), subtracts the quantizer feedback level, and accumulates the result into a saturating 41-bit state register. It also detects loop overload (persistent saturation), resets the integrator, and holds it for a fixed recovery window so the modulator regains stability.

## Interface
- W, 41, datapath width (two's complement); fixed, must match the coefficient stages.
- FB_LEVEL, 2^36, positive feedback magnitude added/subtracted per sample.
- OVL_N, 4, consecutive saturated samples that declare overload (≥2).
- OVL_HOLD, 16, samples held at zero in recovery (≥1).

Reset is asynchronous, active-low.

- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- ce  in  1  sample strobe; one integration step per cycle where ce=1.
- clr  in  1  synchronous clear of all state.
- in  in  W  signed scaled sample from the coefficient stage.
- fb  in  1  quantizer output; 1 → subtract FB_LEVEL, 0 → add FB_LEVEL.
- out  out  W  signed integrator state (registered).
- out_valid  out  1  one-cycle pulse, cycle after each accepted ce.
- sat  out  1  last step saturated.
- recovering  out  1  high while in RECOVER.
- ovf  out  1  sticky; set on first overload.
- ovf_cnt  out  8  overload event count, saturates at 255.

## Operation
- Reset values: out=0, out_valid=0, sat=0, recovering=0, ovf=0, ovf_cnt=0, state=RUN, internal run/hold counters=0.
- Step arithmetic is done in W+2 bits: sum = out + in − (fb ? FB_LEVEL : −FB_LEVEL). Clamp to [−2^40, 2^40−1]. sat=1 iff the value was clamped.
- RUN on ce:
  - out ← clamped sum.
  - If sat, increment sat_run; otherwise sat_run ← 0.
  - If sat and sat_run == OVL_N−1: out ← 0, sat_run ← 0, hold_cnt ← 0, state ← RECOVER, ovf ← 1, ovf_cnt ← min(ovf_cnt+1, 255). sat=1 in this cycle.
- RECOVER on ce:
  - out stays 0, sat=0, `in` and `fb` are ignored, hold_cnt increments.
  - When hold_cnt == OVL_HOLD−1: state ← RUN, hold_cnt ← 0. This gives exactly OVL_HOLD ce strobes in RECOVER.
- recovering = (state == RECOVER), registered.
- clr (synchronous) restores all reset values, including ovf and ovf_cnt. clr beats a simultaneous ce: no step is taken and out_valid=0 the following cycle.
- With ce=0, all state holds and out_valid=0.
- Asynchronous reset mid-recovery returns the block immediately to RUN with out=0.

## Timing
- Latency: ce at cycle n → out, sat, out_valid updated at n+1. The loop path in→out is one register.
- Back-to-back ce (every cycle) is supported at full rate. No backpressure.
- `fb` is sampled together with `in` at the ce cycle. The quantizer may derive `fb` combinationally from `out`.
- The FSM transition and the out=0 write occur in the same cycle as the overload-declaring step.

## Structure
- Shared package ds_pkg:
  - W, SAT_MAX = 2^40−1, SAT_MIN = −2^40.
  - Default FB_LEVEL.
  - State enum {RUN, RECOVER}.
- One sub-module, ds_sat_add: combinational W+2-bit sum with clamp and sat flag. It is reusable by later integrator stages.
- FSM, counters and registers live in ds_integ_stage.

## Test plan
- After reset: in=0, fb=0, one ce → out=68719476736 (2^36), out_valid pulses once, sat=0. Then fb=1, one ce → out=0.
- in=2^39, fb=0, ce every cycle from out=0:
  - Step 1 → out=2^39+2^36, sat=0.
  - Step 2 → out=2^40−1, sat=1.
  - Steps 2..4 saturated (3 consecutive, out held at 2^40−1).
  - Step 5 saturates again → out=0, recovering=1, ovf=1, ovf_cnt=1.
- While in RECOVER, drive in=−2^40, fb=1 for 16 ce → out stays 0. recovering drops after exactly 16 strobes. The 17th ce integrates normally.
- Negative clamp: out=−2^40+10, in=−100, fb=1 → out=−2^40, sat=1. The next non-saturating step clears sat_run (verify via timing to overload).
- clr asserted with ce in the same cycle while in RECOVER with ovf_cnt=3 → next cycle out=0, ovf=0, ovf_cnt=0, recovering=0, out_valid=0.
- Drive 260 overload events → ovf_cnt stops at 255. Assert rst_n low mid-RECOVER → all outputs are zero asynchronously.
